// File: rtl/alu_seq_unit.sv
// alu_seq_unit: execute-stage ALU. The result, the condition-code register
// {N,C,Z} and the issue handshake are all registered. Most ops finish in one
// clock. SHL/SHR (one bit per clock) and MUL (shift-add) are iterative and
// hold off further issue until they finish.
//
// Handshake: an op is accepted at a rising edge when in_valid & in_ready &
// ~flush all hold in the cycle before that edge. in_ready is high only in IDLE.
// in_valid is ignored while in_ready is low. out_valid is a single-cycle pulse
// in the cycle after the completing edge. out and flag keep their values
// between completions.
module alu_seq_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flag_ld,
    input  logic [2:0]       flag_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flag,
    output logic             busy,
    output logic             state_dbg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_NOT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_SETC = 4'h9;
    localparam logic [3:0] OP_CLRC = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    // Shift counts saturate at WIDTH. MUL always takes WIDTH steps.
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

    // Flag bit positions inside the CCR {N,C,Z}.
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FZ = 0;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [2:0]         flag_q, flag_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    // work_q holds the value being shifted, or the multiplier for MUL.
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    // One-cycle arithmetic. Bit WIDTH of each sum is the carry or borrow.
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     sum_sub;
    logic [WIDTH:0]     sum_inc;
    logic [WIDTH:0]     sum_dec;
    logic [WIDTH-1:0]   shl_step;
    logic [WIDTH-1:0]   shr_step;
    logic [2*WIDTH-1:0] prod_step;
    logic               issue;

    assign sum_add   = {1'b0, in1} + {1'b0, in2};
    assign sum_sub   = {1'b0, in1} - {1'b0, in2};
    assign sum_inc   = {1'b0, in2} + (WIDTH+1)'(1);
    assign sum_dec   = {1'b0, in2} - (WIDTH+1)'(1);
    assign shl_step  = {work_q[WIDTH-2:0], 1'b0};
    assign shr_step  = {1'b0, work_q[WIDTH-1:1]};
    assign prod_step = work_q[0] ? (prod_q + mcand_q) : prod_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = ~in_ready;
    assign issue     = in_valid & in_ready & ~flush;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flag      = flag_q;
    assign state_dbg = state_q;

    // Result write-back controls, shared by one-cycle ops and iterative completion.
    logic             wr_out;
    logic             wr_zn;
    logic             wr_c;
    logic             new_c;
    logic [WIDTH-1:0] res;

    // Next-state, datapath step and CCR update.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        flag_d      = flag_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        op_d        = op_q;
        work_d      = work_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        wr_out      = 1'b0;
        wr_zn       = 1'b0;
        wr_c        = 1'b0;
        new_c       = 1'b0;
        res         = '0;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    out_valid_d = 1'b1;
                    case (alu_op)
                        OP_NOT: begin
                            res = ~in2; wr_out = 1'b1; wr_zn = 1'b1;
                        end
                        OP_ADD: begin
                            res = sum_add[WIDTH-1:0]; new_c = sum_add[WIDTH];
                            wr_out = 1'b1; wr_zn = 1'b1; wr_c = 1'b1;
                        end
                        OP_MOV: begin
                            res = in1; wr_out = 1'b1;
                        end
                        OP_SUB: begin
                            res = sum_sub[WIDTH-1:0]; new_c = sum_sub[WIDTH];
                            wr_out = 1'b1; wr_zn = 1'b1; wr_c = 1'b1;
                        end
                        OP_AND: begin
                            res = in1 & in2; wr_out = 1'b1; wr_zn = 1'b1;
                        end
                        OP_OR: begin
                            res = in1 | in2; wr_out = 1'b1; wr_zn = 1'b1;
                        end
                        OP_INC: begin
                            res = sum_inc[WIDTH-1:0]; new_c = sum_inc[WIDTH];
                            wr_out = 1'b1; wr_zn = 1'b1; wr_c = 1'b1;
                        end
                        OP_DEC: begin
                            res = sum_dec[WIDTH-1:0]; new_c = sum_dec[WIDTH];
                            wr_out = 1'b1; wr_zn = 1'b1; wr_c = 1'b1;
                        end
                        OP_SETC: begin
                            new_c = 1'b1; wr_c = 1'b1;
                        end
                        OP_CLRC: begin
                            new_c = 1'b0; wr_c = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (in1 == '0) begin
                                // A zero count passes in2 through and keeps C.
                                res = in2; wr_out = 1'b1; wr_zn = 1'b1;
                            end else begin
                                out_valid_d = 1'b0;
                                state_d     = ST_ITER;
                                op_d        = alu_op;
                                work_d      = in2;
                                cnt_d       = (in1 >= WIDTH_VAL) ? CNT_FULL : in1[CNT_W-1:0];
                            end
                        end
                        OP_MUL: begin
                            out_valid_d = 1'b0;
                            state_d     = ST_ITER;
                            op_d        = alu_op;
                            work_d      = in2;
                            mcand_d     = {{WIDTH{1'b0}}, in1};
                            prod_d      = '0;
                            cnt_d       = CNT_FULL;
                        end
                        default: begin
                            // NOP and reserved codes: only the completion pulse.
                        end
                    endcase
                end
            end

            ST_ITER: begin
                if (flush) begin
                    // Abandon the op. The partial result never reaches out/flag.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (op_q == OP_MUL) begin
                        prod_d  = prod_step;
                        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                        work_d  = shr_step;
                        res     = prod_step[WIDTH-1:0];
                        new_c   = |prod_step[2*WIDTH-1:WIDTH];
                    end else if (op_q == OP_SHL) begin
                        work_d = shl_step;
                        res    = shl_step;
                        new_c  = work_q[WIDTH-1];
                    end else begin
                        work_d = shr_step;
                        res    = shr_step;
                        new_c  = work_q[0];
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        wr_out      = 1'b1;
                        wr_zn       = 1'b1;
                        wr_c        = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_out) begin
            out_d = res;
        end
        if (wr_zn) begin
            flag_d[FN] = res[WIDTH-1];
            flag_d[FZ] = (res == '0);
        end
        if (wr_c) begin
            flag_d[FC] = new_c;
        end
        // An interrupt-return restore beats any op's flag update on the same edge.
        if (flag_ld) begin
            flag_d = flag_in;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            flag_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            op_q        <= '0;
            work_q      <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            work_q      <= work_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit: directed cases followed by random ops, checked
// against an arithmetic reference model of the result, CCR and latency.
module tb_alu_seq_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         flag_ld;
    logic [2:0]   flag_in;
    logic         out_valid;
    logic [W-1:0] out;
    logic [2:0]   flag;
    logic         busy;
    logic         state_dbg;

    int checks = 0;
    int errors = 0;

    // Shadow architectural state: last result and CCR.
    logic [W-1:0] m_out;
    logic [2:0]   m_flag;
    logic [W-1:0] exp_q[$];

    alu_seq_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .in1(in1), .in2(in2), .flag_ld(flag_ld), .flag_in(flag_in),
        .out_valid(out_valid), .out(out), .flag(flag), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result, CCR and number of iterative cycles (0 = one-cycle).
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eo, output logic [2:0] ef, output int lat);
        longint unsigned p;
        int n;
        logic c;
        logic zn;
        eo = m_out; c = m_flag[1]; zn = 1'b1; lat = 0;
        n = (a > W) ? W : int'(a);
        case (op)
            4'h1: eo = ~b;
            4'h2: begin p = longint'(a) + longint'(b); eo = W'(p); c = (p >= (64'd1 << W)); end
            4'h3: begin eo = a; zn = 1'b0; end
            4'h4: begin eo = a - b; c = (a < b); end
            4'h5: eo = a & b;
            4'h6: eo = a | b;
            4'h7: begin eo = b + 1'b1; c = (b == {W{1'b1}}); end
            4'h8: begin eo = b - 1'b1; c = (b == '0); end
            4'h9: begin c = 1'b1; zn = 1'b0; end
            4'hA: begin c = 1'b0; zn = 1'b0; end
            4'hB: begin
                eo = (n == W) ? '0 : W'(longint'(b) << n);
                if (n > 0) c = b[W-n];
                lat = n;
            end
            4'hC: begin
                eo = (n == W) ? '0 : W'(longint'(b) >> n);
                if (n > 0) c = b[n-1];
                lat = n;
            end
            4'hD: begin
                p = longint'(a) * longint'(b);
                eo = W'(p); c = ((p >> W) != 0); lat = W;
            end
            default: zn = 1'b0;
        endcase
        ef = m_flag;
        ef[1] = c;
        if (zn) begin
            ef[2] = eo[W-1];
            ef[0] = (eo == '0);
        end
    endtask

    // Driver: issue one op, follow it to completion and score it.
    // spam keeps in_valid high with an ADD while busy; the unit must ignore it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic spam, input logic ld,
                          input logic [2:0] ld_val);
        logic [W-1:0] eo;
        logic [2:0]   ef;
        int           lat;
        model(op, a, b, eo, ef, lat);
        if (ld) ef = ld_val;
        exp_q.push_back(eo);
        check({tag, "_ready_before"}, in_ready, 1);
        alu_op = op; in1 = a; in2 = b; in_valid = 1'b1;
        flag_ld = ld; flag_in = ld_val;
        step();
        in_valid = 1'b0; flag_ld = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_no_valid"}, out_valid, 0);
            if (spam) begin
                in_valid = 1'b1; alu_op = 4'h2; in1 = 16'h1111; in2 = 16'h2222;
            end
            step();
        end
        in_valid = 1'b0;
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_out"}, out, exp_q.pop_front());
        check({tag, "_flag"}, flag, ef);
        check({tag, "_ready_after"}, in_ready, 1);
        m_out = eo; m_flag = ef;
    endtask

    initial begin
        logic [3:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = '0; in1 = '0; in2 = '0;
        flag_ld = 1'b0; flag_in = '0;
        m_out = '0; m_flag = '0;

        // Reset values
        #12;
        check("rst_out", out, 0);
        check("rst_flag", flag, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b1;
        step();

        // Carry/negative and zero results
        run_op("add_7fff", 4'h2, 16'h7FFF, 16'h0001, 0, 0, 3'b000);
        check("add_7fff_val", out, 16'h8000);
        check("add_7fff_ccr", flag, 3'b100);
        run_op("sub_5_5", 4'h4, 16'd5, 16'd5, 0, 0, 3'b000);
        check("sub_5_5_ccr", flag, 3'b001);
        step();
        check("pulse_drops", out_valid, 0);

        // C kept across logic ops
        run_op("setc", 4'h9, 16'h0, 16'h0, 0, 0, 3'b000);
        run_op("and_c_kept", 4'h5, 16'h00F0, 16'h0F00, 0, 0, 3'b000);
        check("and_ccr", flag, 3'b011);
        run_op("clrc", 4'hA, 16'h0, 16'h0, 0, 0, 3'b000);
        check("clrc_ccr", flag, 3'b001);

        // Shifts: short, saturated, zero count
        run_op("shl_3", 4'hB, 16'd3, 16'h8001, 0, 0, 3'b000);
        check("shl_3_val", out, 16'h0008);
        run_op("shl_20", 4'hB, 16'd20, 16'h8001, 0, 0, 3'b000);
        check("shl_20_ccr", flag, 3'b011);
        run_op("shr_0", 4'hC, 16'd0, 16'h8001, 0, 0, 3'b000);
        run_op("shr_16", 4'hC, 16'd16, 16'h8000, 0, 0, 3'b000);

        // MUL with a competing ADD during busy
        run_op("mul_ovf", 4'hD, 16'h0100, 16'h0100, 1, 0, 3'b000);
        check("mul_ovf_ccr", flag, 3'b011);
        step();
        check("mul_spam_dropped", out_valid, 0);

        // Flush mid-MUL
        run_op("mov_seed", 4'h3, 16'h1234, 16'h0, 0, 0, 3'b000);
        alu_op = 4'hD; in1 = 16'h0003; in2 = 16'h0005; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_no_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        check("flush_out", out, m_out);
        check("flush_flag", flag, m_flag);
        step();
        check("flush_quiet", out_valid, 0);

        // Flush in IDLE drops the same-cycle issue
        alu_op = 4'h2; in1 = 16'h0001; in2 = 16'h0001; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_issue_valid", out_valid, 0);
        check("flush_issue_out", out, m_out);

        // CCR restore wins over a same-edge ADD
        run_op("add_fld", 4'h2, 16'h0001, 16'h0001, 0, 1, 3'b101);
        check("add_fld_out", out, 16'h0002);

        // Asynchronous reset in the middle of SHR
        alu_op = 4'hC; in1 = 16'd10; in2 = 16'hFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_flag", flag, 0);
        check("arst_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        m_out = '0; m_flag = '0;
        step();
        rst = 1'b1;
        step();
        run_op("after_rst", 4'h7, 16'h0, 16'hFFFF, 0, 0, 3'b000);

        // Random ops
        for (int i = 0; i < 60; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = W'($urandom);
            r_b  = W'($urandom);
            if (r_op == 4'hB || r_op == 4'hC) r_a = W'($urandom_range(0, 20));
            run_op("rand", r_op, r_a, r_b, 1'($urandom_range(0, 1)), 0, 3'b000);
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("rand_idle", out_valid, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck design still ends with a report.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
